dcache_ctrl: RTL and testbench

- Controller for the 2-way, 16-set, 256-bit-line data cache SRAM: the initiator of the SRAM lookup/write interface.
- Accepts single-word CPU loads and stores, looks them up in the SRAM, and stalls the CPU on a miss.
- On a miss it writes back a dirty victim to memory, refills the line, then replays the access.
- Sits between the CPU MEM stage, the dcache SRAM, and the line-wide main-memory port.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_line_merge.sv | 22 ++
 rtl/dcache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: address slicing,
// SRAM tag field layout and the controller state encoding.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 256;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 23;

  // Word select within a line is addr[4:2].
  localparam int WORD_SEL_W   = 3;
  localparam int WORD_SEL_LSB = 2;

  // Set index is addr[8:5]; tag is addr[31:9].
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_LSB   = OFFSET_W + INDEX_W;

  // SRAM tag field is {valid, dirty, tag}.
  localparam int SRAM_TAG_W = TAG_W + 2;
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS      = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_line_merge.sv
// Word select (loads) and word replace (stores) on a 256-bit cache line,
// indexed by the 3-bit word number addr[4:2].
module dcache_line_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]     line_i,
  input  logic [WORD_SEL_W-1:0] word_idx_i,
  input  logic [WORD_W-1:0]     word_i,
  output logic [WORD_W-1:0]     word_o,
  output logic [LINE_W-1:0]     line_o
);

  // Extract the addressed word and build the line with that word replaced.
  always_comb begin
    // NOTE: every output gets a value before any conditional/indexed write,
    // so no path leaves a bit unassigned and no latch is inferred.
    line_o = line_i;
    word_o = line_i[word_idx_i*WORD_W +: WORD_W];
    line_o[word_idx_i*WORD_W +: WORD_W] = word_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: drives the 2-way dcache SRAM lookup/write interface,
// stalls the CPU on a miss, writes back a dirty victim, refills the line and
// replays the access. Optional performance counters are built when the macro
// DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [WORD_W-1:0]     cpu_data_i,
  output logic [WORD_W-1:0]     cpu_data_o,
  output logic                  cpu_stall_o,
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  output logic [INDEX_W-1:0]    sram_addr_o,
  output logic [SRAM_TAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  input  logic [SRAM_TAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
  output logic [31:0]           wb_cnt_o
`endif
);

  state_t                  state_q;
  logic [SRAM_TAG_W-1:0]   victim_tag_q;
  logic [LINE_W-1:0]       victim_line_q;

  logic [INDEX_W-1:0]      index;
  logic [TAG_W-1:0]        tag;
  logic [WORD_W-1:0]       load_word;
  logic [LINE_W-1:0]       store_line;
  logic                    lookup_miss;
  logic                    victim_dirty;
  logic [1:0]              unused_addr_bits;

  assign index            = cpu_addr_i[TAG_LSB-1:INDEX_LSB];
  assign tag              = cpu_addr_i[ADDR_W-1:TAG_LSB];
  assign lookup_miss      = (state_q == IDLE) && cpu_req_i && !sram_hit_i;
  assign victim_dirty     = victim_tag_q[VALID_BIT] && victim_tag_q[DIRTY_BIT];
  // Byte-within-word bits do not matter for word-sized accesses.
  assign unused_addr_bits = cpu_addr_i[WORD_SEL_LSB-1:0];

  dcache_line_merge u_line_merge (
    .line_i     (sram_data_i),
    .word_idx_i (cpu_addr_i[WORD_SEL_LSB +: WORD_SEL_W]),
    .word_i     (cpu_data_i),
    .word_o     (load_word),
    .line_o     (store_line)
  );

  // Controller state sequencing: lookup, optional writeback, refill, replay.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (cpu_req_i && !sram_hit_i) state_q <= MISS;
        MISS:      state_q <= victim_dirty ? WRITEBACK : ALLOCATE;
        WRITEBACK: if (mem_ack_i) state_q <= ALLOCATE;
        ALLOCATE:  if (mem_ack_i) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Capture the LRU victim reported by the SRAM on the missing lookup.
  always_ff @(posedge clk_i) begin
    // NOTE: victim storage is pure data qualified by the state register, so it
    // carries no reset; it is always reloaded before it is consumed.
    if (lookup_miss) begin
      victim_tag_q  <= sram_tag_i;
      victim_line_q <= sram_data_i;
    end
  end

  // Output decode from the current state and the live CPU/SRAM/memory inputs.
  always_comb begin
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          sram_enable_o = 1'b1;
          sram_addr_o   = index;
          if (!sram_hit_i) begin
            cpu_stall_o = 1'b1;
          end else if (cpu_we_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = store_line;
            sram_tag_o   = {1'b1, 1'b1, tag};
          end else begin
            cpu_data_o = load_word;
          end
        end
      end
      MISS: begin
        cpu_stall_o = 1'b1;
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_q[TAG_W-1:0], index, {OFFSET_W{1'b0}}};
        mem_data_o   = victim_line_q;
      end
      ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_addr_o   = index;
          sram_data_o   = mem_data_i;
          sram_tag_o    = {1'b1, 1'b0, tag};
        end
      end
      default: begin
        cpu_stall_o = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic replay_q;

  // Hit/miss/writeback event counters; the post-refill replay is not a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      replay_q   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      replay_q <= (state_q == ALLOCATE) && mem_ack_i;
      if ((state_q == IDLE) && cpu_req_i && sram_hit_i && !replay_q)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (lookup_miss)
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if ((state_q == WRITEBACK) && mem_ack_i)
        wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold load miss and refill, store hit,
// dirty-victim writeback, slow refill with held request, stray ack, and reset
// during writeback. Counter checks are built when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  wb_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  dcache_ctrl dut (
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt),
    .wb_cnt_o      (wb_cnt),
`endif
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cpu_req_i     (cpu_req_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .sram_enable_o (sram_enable_o),
    .sram_write_o  (sram_write_o),
    .sram_addr_o   (sram_addr_o),
    .sram_tag_o    (sram_tag_o),
    .sram_data_o   (sram_data_o),
    .sram_tag_i    (sram_tag_i),
    .sram_data_i   (sram_data_i),
    .sram_hit_i    (sram_hit_i),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 2ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] fill_line;
    logic [255:0] store_line;
    logic [255:0] line2;
    logic [255:0] junk_line;
    int           stall_cycles;
    bit           hold_ok;

    // Refill line for 0x100: word0=0x12345678, word1=0xDEADBEEF, rest 0xA000000k.
    for (int k = 0; k < 8; k++) fill_line[k*32 +: 32] = 32'hA000_0000 + k;
    fill_line[31:0]  = 32'h1234_5678;
    fill_line[63:32] = 32'hDEAD_BEEF;
    store_line           = fill_line;
    store_line[95:64]    = 32'h1234_5678;
    for (int k = 0; k < 8; k++) line2[k*32 +: 32] = 32'h5000_0000 + k;
    junk_line = {8{32'hBAD0_BAD0}};

    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_data_i  = '0;
    sram_tag_i  = '0;
    sram_data_i = '0;
    sram_hit_i  = 1'b0;
    mem_data_i  = '0;
    mem_ack_i   = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_stall",    cpu_stall_o,   1'b0);
    check("rst_sram_en",  sram_enable_o, 1'b0);
    check("rst_mem_en",   mem_enable_o,  1'b0);
    check("rst_cpu_data", cpu_data_o,    32'h0);

    // 1: cold load 0x104 misses on an invalid victim and refills from 0x100.
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0104;
    sram_hit_i = 1'b0;
    #1;
    check("s1_lookup_stall", cpu_stall_o,   1'b1);
    check("s1_lookup_en",    sram_enable_o, 1'b1);
    check("s1_lookup_set",   sram_addr_o,   4'd8);
    stall_cycles = 1;
    step();
    // SRAM outputs are meaningless now; a valid+dirty pattern exposes any
    // use of the live tag instead of the captured one.
    sram_tag_i  = 25'h1FF_FFFF;
    sram_data_i = junk_line;
    #1;
    check("s1_miss_stall", cpu_stall_o,  1'b1);
    check("s1_miss_mem",   mem_enable_o, 1'b0);
    stall_cycles += int'(cpu_stall_o);
    step();
    #1;
    check("s1_alloc_en",   mem_enable_o, 1'b1);
    check("s1_alloc_wr",   mem_write_o,  1'b0);
    check("s1_alloc_addr", mem_addr_o,   32'h0000_0100);
    stall_cycles += int'(cpu_stall_o);
    step();
    #1;
    stall_cycles += int'(cpu_stall_o);
    step();
    mem_ack_i  = 1'b1;
    mem_data_i = fill_line;
    #1;
    check("s1_fill_wr",    sram_write_o, 1'b1);
    check("s1_fill_tag",   sram_tag_o,   25'h100_0000);
    check("s1_fill_data",  sram_data_o,  fill_line);
    check("s1_fill_set",   sram_addr_o,  4'd8);
    stall_cycles += int'(cpu_stall_o);
    step();
    mem_ack_i   = 1'b0;
    mem_data_i  = '0;
    sram_hit_i  = 1'b1;
    sram_tag_i  = 25'h100_0000;
    sram_data_i = fill_line;
    #1;
    check("s1_replay_data",  cpu_data_o,   32'hDEAD_BEEF);
    check("s1_replay_stall", cpu_stall_o,  1'b0);
    check("s1_replay_nowr",  sram_write_o, 1'b0);
    check("s1_penalty",      stall_cycles, 5);

    // 2: store hit to 0x108 merges word2 and marks the line dirty.
    step();
    cpu_we_i   = 1'b1;
    cpu_addr_i = 32'h0000_0108;
    cpu_data_i = 32'h1234_5678;
    #1;
    check("s2_store_wr",    sram_write_o, 1'b1);
    check("s2_store_tag",   sram_tag_o,   25'h180_0000);
    check("s2_store_data",  sram_data_o,  store_line);
    check("s2_store_stall", cpu_stall_o,  1'b0);

    // 3: load 0x500 evicts the dirty 0x100 line before refilling.
    step();
    cpu_we_i    = 1'b0;
    cpu_data_i  = '0;
    cpu_addr_i  = 32'h0000_0500;
    sram_hit_i  = 1'b0;
    sram_tag_i  = 25'h180_0000;
    sram_data_i = store_line;
    #1;
    check("s3_lookup_stall", cpu_stall_o, 1'b1);
    step();
    sram_tag_i  = '0;
    sram_data_i = junk_line;
    step();
    #1;
    check("s3_wb_en",    mem_enable_o,      1'b1);
    check("s3_wb_wr",    mem_write_o,       1'b1);
    check("s3_wb_addr",  mem_addr_o,        32'h0000_0100);
    check("s3_wb_data",  mem_data_o,        store_line);
    check("s3_wb_word0", mem_data_o[31:0],  32'h1234_5678);
    step();
    mem_ack_i = 1'b1;
    #1;
    check("s3_wb_hold", mem_data_o, store_line);
    step();
    mem_ack_i = 1'b0;
    #1;
    check("s3_alloc_en",   mem_enable_o, 1'b1);
    check("s3_alloc_wr",   mem_write_o,  1'b0);
    check("s3_alloc_addr", mem_addr_o,   32'h0000_0500);

    // 4: the refill ack is withheld for 10 cycles; request must stay put.
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!mem_enable_o || mem_write_o || !cpu_stall_o || mem_addr_o !== 32'h0000_0500 ||
          sram_write_o)
        hold_ok = 1'b0;
      step();
      #1;
    end
    check("s4_alloc_hold", hold_ok, 1'b1);
    mem_ack_i  = 1'b1;
    mem_data_i = line2;
    #1;
    check("s4_fill_tag",  sram_tag_o,  25'h100_0002);
    check("s4_fill_data", sram_data_o, line2);
    step();
    mem_ack_i   = 1'b0;
    mem_data_i  = '0;
    sram_hit_i  = 1'b1;
    sram_tag_i  = 25'h100_0002;
    sram_data_i = line2;
    #1;
    check("s4_replay_data",  cpu_data_o,  32'h5000_0000);
    check("s4_replay_stall", cpu_stall_o, 1'b0);

    // Stray ack while idle with no request.
    step();
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    check("stray_mem_en",  mem_enable_o,  1'b0);
    check("stray_stall",   cpu_stall_o,   1'b0);
    check("stray_sram_en", sram_enable_o, 1'b0);
`ifdef DCACHE_PERF_CNT_EN
    check("cnt_hit",  hit_cnt,  32'd1);
    check("cnt_miss", miss_cnt, 32'd2);
    check("cnt_wb",   wb_cnt,   32'd1);
`endif
    step();
    mem_ack_i  = 1'b0;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h0000_0504;
    #1;
    check("stray_after_data",  cpu_data_o,  32'h5000_0001);
    check("stray_after_stall", cpu_stall_o, 1'b0);

    // 5: reset while writing back the dirty 0x300 victim for a load of 0x700.
    step();
    cpu_addr_i  = 32'h0000_0700;
    sram_hit_i  = 1'b0;
    sram_tag_i  = 25'h180_0001;
    sram_data_i = line2;
    step();
    step();
    #1;
    check("s5_wb_en",   mem_enable_o, 1'b1);
    check("s5_wb_addr", mem_addr_o,   32'h0000_0300);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    step();
    rst_i = 1'b0;
    #1;
    check("s5_rst_mem_en",  mem_enable_o,  1'b0);
    check("s5_rst_stall",   cpu_stall_o,   1'b0);
    check("s5_rst_sram_en", sram_enable_o, 1'b0);
`ifdef DCACHE_PERF_CNT_EN
    check("s5_rst_cnt_hit",  hit_cnt,  32'd0);
    check("s5_rst_cnt_miss", miss_cnt, 32'd0);
    check("s5_rst_cnt_wb",   wb_cnt,   32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
